fft_out_reorder: RTL and testbench
==================================

Name: fft_out_reorder

Overview:
Output-side reorder buffer for the 32-point SDF FFT pipeline. It sits after the last butterfly stage and consumes its streaming output, which arrives in bit-reversed index order. It re-emits each frame in natural index order with frame markers and a downstream ready handshake. Storage is a ping-pong pair of N-entry banks, so continuous back-to-back frames stream without gaps.

Parameters:
N, 32, FFT length (points per frame); power of two.
LOG2N, 5, log2(N); index/counter width.
DW, 16, signed width of each real/imag sample.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
valid_i  input  1  input sample valid; no backpressure toward the FFT.
data_in_r  input  DW  signed real part, bit-reversed order.
data_in_i  input  DW  signed imag part, bit-reversed order.
ready_i  input  1  downstream accepts the output sample this cycle.
valid_o  output  1  output sample valid.
data_out_r  output  DW  signed real part, natural order.
data_out_i  output  DW  signed imag part, natural order.
index_o  output  LOG2N  natural frequency index of the current output sample.
sop_o  output  1  high with index_o==0.
eop_o  output  1  high with index_o==N-1.
overflow_o  output  1  sticky error flag; input sample dropped.

Behaviour:
- Reset (async, rst_n low): valid_o, sop_o, eop_o, overflow_o, index_o, data_out_* = 0. wcnt=0, wsel=0, rcnt=0, rsel=0, full[1:0]=0, read FSM = IDLE. Bank contents are not reset. Reset mid-frame discards all partial and full frames.
- Write side:
  - On each edge with valid_i=1 and full[wsel]=0: bank[wsel][bitrev(wcnt)] <= data_in, then wcnt++.
  - When wcnt==N-1 is written: full[wsel] <= 1, wsel toggles, wcnt wraps to 0.
  - Gaps in valid_i are allowed; wcnt holds during a gap.
- Overflow: valid_i=1 while full[wsel]=1, using the pre-edge value of full → sample discarded, wcnt unchanged, overflow_o <= 1, which is sticky until reset.
  - This applies even if the reader clears full[wsel] on the same edge.
- Read FSM, states IDLE and STREAM. The output register loads when (!valid_o || ready_i).
  - IDLE: if full[rsel], load bank[rsel][0] and go to STREAM. valid_o=1, index_o=0, sop_o=1.
  - STREAM: on each load, rcnt++ and output bank[rsel][rcnt].
  - When the loaded sample is rcnt==N-1: eop_o=1 with it, full[rsel] <= 0, rsel toggles, rcnt <= 0.
  - At that edge, if full[other] was already 1, the next load continues directly with index 0 of the next frame (no bubble). Otherwise go to IDLE, and valid_o drops once the last sample is accepted.
  - Stall (valid_o=1, ready_i=0): data_out_*, index_o, sop_o, eop_o, valid_o hold stable.
- Latency: with ready_i=1, the first output (index 0) is valid in the cycle after the edge that set full. That is 1 clock after the edge sampling the frame's last input.
- Throughput: 1 sample/clock sustained. With ready_i held high, the writer never overflows.
- Simultaneous full-set by writer and full-clear by reader on different banks at the same edge: both take effect.
- Arithmetic: data is passed through unmodified; no scaling or rounding.

Decomposition:
- Shared package fft_pkg: N, LOG2N, DW constants; bitrev function (LOG2N-bit reversal); read-FSM state encoding (IDLE, STREAM).
- One sub-module: fft_pingpong_ram. It holds 2×N×(2·DW) register storage with one synchronous write port (bank, addr, data) and one combinational read port (bank, addr).

Test Plan:
- Single frame: 32 contiguous inputs, sample k carries data_r = bitrev(k), data_i = -bitrev(k), ready_i=1. Required: valid_o starts 1 clock after the last input; data_r = 0..31 in order, data_i = 0..-31; sop_o at index 0; eop_o at index 31; overflow_o=0.
- Back-to-back: 3 frames with valid_i held high for 96 cycles, ready_i=1. Required: 96 consecutive valid_o cycles with no bubble; frame f sample n equals 100·f+n when the input encodes 100·f+bitrev(k).
- Stall: during output, drop ready_i at index 5 for 4 cycles. Required: outputs hold index 5 with stable data; resumes at 6; no loss; eop_o at 31.
- Overflow: ready_i=0 throughout, send 3 full frames. Required: frames 1–2 fill both banks; the first sample of frame 3 sets overflow_o=1. Then raise ready_i: frames 1 and 2 emerge intact in natural order.
- Gapped input: valid_i toggling 1-0 across one frame. Required: output still equals natural order 0..31.
- Reset mid-operation: assert rst_n low at write index 17 of frame 2 while frame 1 is streaming at index 10. Required: all outputs 0 immediately; the next full frame after release is emitted correctly from index 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, read-FSM encoding and index helper for the FFT output reorder path.
package fft_pkg;

  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int DW    = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

  // Reverses the LOG2N index bits; maps the FFT's bit-reversed order onto natural order.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = v[LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Streaming bus of the reorder block: bit-reversed input side and natural-order output side.
interface fft_out_reorder_if;
  import fft_pkg::*;

  logic                    valid_i;
  logic signed [DW-1:0]    data_in_r;
  logic signed [DW-1:0]    data_in_i;
  logic                    ready_i;
  logic                    valid_o;
  logic signed [DW-1:0]    data_out_r;
  logic signed [DW-1:0]    data_out_i;
  logic [LOG2N-1:0]        index_o;
  logic                    sop_o;
  logic                    eop_o;
  logic                    overflow_o;

  // Reorder block side.
  modport slave (
    input  valid_i, data_in_r, data_in_i, ready_i,
    output valid_o, data_out_r, data_out_i, index_o, sop_o, eop_o, overflow_o
  );

  // Upstream FFT / downstream consumer side.
  modport master (
    output valid_i, data_in_r, data_in_i, ready_i,
    input  valid_o, data_out_r, data_out_i, index_o, sop_o, eop_o, overflow_o
  );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two N-entry banks of packed {real, imag} samples: one synchronous write port, one combinational read port.
module fft_pingpong_ram
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                i_we,
  input  logic                i_wr_bank,
  input  logic [LOG2N-1:0]    i_wr_addr,
  input  logic [2*DW-1:0]     i_wr_data,
  input  logic                i_rd_bank,
  input  logic [LOG2N-1:0]    i_rd_addr,
  output logic [2*DW-1:0]     o_rd_data
);

  logic [2*DW-1:0] r_mem [2][N];

  // Sample storage; contents are deliberately not reset, the full flags say what is valid.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_bank][i_rd_addr];

endmodule

// File: rtl/fft_out_reorder.sv
// Output reorder buffer: writes bit-reversed FFT output into a ping-pong bank and
// streams each complete frame out in natural order with sop/eop and a ready handshake.
//
// Read FSM states:
//   state  | meaning
//   IDLE   | no frame being streamed; start one as soon as bank[rsel] is full
//   STREAM | emitting bank[rsel] samples, r_rcnt is the next index to load
module fft_out_reorder
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fft_out_reorder_if.slave  bus
);

  // Write side
  logic [LOG2N-1:0]      r_wcnt;
  logic                  r_wsel;
  logic [1:0]            r_full;
  logic                  r_overflow;
  logic                  w_wr_en;
  logic                  w_wr_last;
  logic [1:0]            w_full_set;
  logic [1:0]            w_full_clr;

  // Read side
  rd_state_t             r_state;
  rd_state_t             w_state_nx;
  logic [LOG2N-1:0]      r_rcnt;
  logic [LOG2N-1:0]      w_rcnt_nx;
  logic                  r_rsel;
  logic                  w_rsel_nx;
  logic                  w_load;
  logic                  w_out_load;
  logic                  w_out_drop;
  logic [LOG2N-1:0]      w_rd_addr;
  logic [2*DW-1:0]       w_rd_data;

  // Output register
  logic                  r_valid;
  logic                  r_sop;
  logic                  r_eop;
  logic [LOG2N-1:0]      r_index;
  logic signed [DW-1:0]  r_data_r;
  logic signed [DW-1:0]  r_data_i;

  // A sample is dropped whenever the bank it targets is still waiting to be read.
  assign w_wr_en    = bus.valid_i && !r_full[r_wsel];
  assign w_wr_last  = w_wr_en && (r_wcnt == LOG2N'(N-1));
  assign w_full_set = w_wr_last ? {r_wsel, ~r_wsel} : 2'b00;

  // The output register may take a new sample when empty or when its sample is being taken.
  assign w_load = !r_valid || bus.ready_i;

  fft_pingpong_ram u_ram (
    .clk       (clk),
    .i_we      (w_wr_en),
    .i_wr_bank (r_wsel),
    .i_wr_addr (bitrev(r_wcnt)),
    .i_wr_data ({bus.data_in_r, bus.data_in_i}),
    .i_rd_bank (r_rsel),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Write counter, bank select and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt     <= '0;
      r_wsel     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wcnt <= w_wr_last ? '0 : r_wcnt + 1'b1;
        if (w_wr_last) begin
          r_wsel <= ~r_wsel;
        end
      end
      if (bus.valid_i && r_full[r_wsel]) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Full flags: writer sets and reader clears always target different banks, so both can land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_rsel  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_rcnt  <= w_rcnt_nx;
      r_rsel  <= w_rsel_nx;
    end
  end

  // Read FSM next state, read address and output-register control.
  always_comb begin
    w_state_nx = r_state;
    w_rcnt_nx  = r_rcnt;
    w_rsel_nx  = r_rsel;
    w_rd_addr  = r_rcnt;
    w_out_load = 1'b0;
    w_out_drop = 1'b0;
    w_full_clr = 2'b00;
    case (r_state)
      IDLE: begin
        w_rd_addr = '0;
        if (w_load) begin
          if (r_full[r_rsel]) begin
            w_out_load = 1'b1;
            w_rcnt_nx  = LOG2N'(1);
            w_state_nx = STREAM;
          end else begin
            w_out_drop = 1'b1;
          end
        end
      end
      STREAM: begin
        if (w_load) begin
          w_out_load = 1'b1;
          if (r_rcnt == LOG2N'(N-1)) begin
            w_full_clr = {r_rsel, ~r_rsel};
            w_rsel_nx  = ~r_rsel;
            w_rcnt_nx  = '0;
            // Continue straight into the other bank when it is already complete.
            w_state_nx = r_full[~r_rsel] ? STREAM : IDLE;
          end else begin
            w_rcnt_nx = r_rcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // Output register; holds everything stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_index  <= '0;
      r_data_r <= '0;
      r_data_i <= '0;
    end else if (w_out_load) begin
      r_valid  <= 1'b1;
      r_sop    <= (w_rd_addr == '0);
      r_eop    <= (w_rd_addr == LOG2N'(N-1));
      r_index  <= w_rd_addr;
      r_data_r <= $signed(w_rd_data[2*DW-1:DW]);
      r_data_i <= $signed(w_rd_data[DW-1:0]);
    end else if (w_out_drop) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end
  end

  assign bus.valid_o    = r_valid;
  assign bus.sop_o      = r_sop;
  assign bus.eop_o      = r_eop;
  assign bus.index_o    = r_index;
  assign bus.data_out_r = r_data_r;
  assign bus.data_out_i = r_data_i;
  assign bus.overflow_o = r_overflow;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for the FFT output reorder buffer.
module tb_fft_out_reorder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fft_out_reorder_if bus();

  fft_out_reorder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_cnt = 0;

  typedef struct {
    int r;
    int i;
    int idx;
    bit sop;
    bit eop;
    int cyc;
  } samp_t;

  samp_t rx[$];

  function automatic int tb_bitrev(int k);
    int r;
    r = 0;
    for (int b = 0; b < 5; b++) begin
      if (k[b]) r = r | (1 << (4 - b));
    end
    return r;
  endfunction

  // Records any sample accepted at the coming edge, then advances one clock.
  task automatic tick();
    samp_t s;
    if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
      s.r   = int'(bus.data_out_r);
      s.i   = int'(bus.data_out_i);
      s.idx = int'(bus.index_o);
      s.sop = bus.sop_o;
      s.eop = bus.eop_o;
      s.cyc = cyc_cnt;
      rx.push_back(s);
    end
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic drive(int r, int i);
    bus.valid_i   = 1'b1;
    bus.data_in_r = 16'(r);
    bus.data_in_i = 16'(i);
  endtask

  task automatic apply_reset();
    bus.valid_i   = 1'b0;
    bus.data_in_r = '0;
    bus.data_in_i = '0;
    bus.ready_i   = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx.delete();
  endtask

  task automatic collect(int want, int budget);
    int guard;
    guard = 0;
    while (rx.size() < want && guard < budget) begin
      tick();
      guard++;
    end
  endtask

  task automatic test_reset();
    bus.valid_i   = 1'b1;
    bus.data_in_r = 16'sd123;
    bus.data_in_i = -16'sd45;
    bus.ready_i   = 1'b1;
    rst_n = 1'b0;
    #3;
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.sop_o !== 1'b0 || bus.eop_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got valid=%b sop=%b eop=%b want 0 0 0", bus.valid_o, bus.sop_o, bus.eop_o);
    end
    vectors++;
    if (bus.index_o !== 5'd0 || bus.overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_index_ovf: got index=%0d ovf=%b want 0 0", bus.index_o, bus.overflow_o);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.data_out_r !== 16'd0 || bus.data_out_i !== 16'd0 || bus.valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: got r=%0d i=%0d valid=%b want 0 0 0", bus.data_out_r, bus.data_out_i, bus.valid_o);
    end
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    apply_reset();
    for (int k = 0; k < 32; k++) begin
      drive(tb_bitrev(k), -tb_bitrev(k));
      tick();
    end
    bus.valid_i = 1'b0;
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL sf_early: got valid=%b want 0 right after last input edge", bus.valid_o);
    end
    tick();
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.index_o !== 5'd0 || bus.sop_o !== 1'b1) begin
      miscompares++;
      $display("FAIL sf_first: got valid=%b index=%0d sop=%b want 1 0 1", bus.valid_o, bus.index_o, bus.sop_o);
    end
    collect(32, 60);
    vectors++;
    if (rx.size() != 32) begin
      miscompares++;
      $display("FAIL sf_count: got %0d samples want 32", rx.size());
    end
    for (int n = 0; n < 32 && n < rx.size(); n++) begin
      vectors++;
      if (rx[n].r != n || rx[n].i != -n || rx[n].idx != n || rx[n].sop != (n == 0) || rx[n].eop != (n == 31)) begin
        miscompares++;
        $display("FAIL sf_sample%0d: got r=%0d i=%0d idx=%0d sop=%b eop=%b want %0d %0d %0d %b %b",
                 n, rx[n].r, rx[n].i, rx[n].idx, rx[n].sop, rx[n].eop, n, -n, n, n == 0, n == 31);
      end
    end
    vectors++;
    if (bus.overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL sf_overflow: got %b want 0", bus.overflow_o);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int v;
    apply_reset();
    c0 = cyc_cnt;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 32; k++) begin
        v = 100 * f + tb_bitrev(k);
        drive(v, -v);
        tick();
      end
    end
    bus.valid_i = 1'b0;
    collect(96, 120);
    vectors++;
    if (rx.size() != 96) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d samples want 96", rx.size());
    end
    if (rx.size() > 0) begin
      vectors++;
      if (rx[0].cyc != c0 + 33) begin
        miscompares++;
        $display("FAIL b2b_latency: got first accept at cycle %0d want %0d", rx[0].cyc, c0 + 33);
      end
    end
    for (int j = 0; j < 96 && j < rx.size(); j++) begin
      int f;
      int n;
      f = j / 32;
      n = j % 32;
      vectors++;
      if (rx[j].r != 100 * f + n || rx[j].i != -(100 * f + n) || rx[j].idx != n ||
          rx[j].sop != (n == 0) || rx[j].eop != (n == 31) || rx[j].cyc != rx[0].cyc + j) begin
        miscompares++;
        $display("FAIL b2b_sample%0d: got r=%0d i=%0d idx=%0d sop=%b eop=%b cyc=%0d want %0d %0d %0d %b %b %0d",
                 j, rx[j].r, rx[j].i, rx[j].idx, rx[j].sop, rx[j].eop, rx[j].cyc,
                 100 * f + n, -(100 * f + n), n, n == 0, n == 31, rx[0].cyc + j);
      end
    end
    vectors++;
    if (bus.overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_overflow: got %b want 0", bus.overflow_o);
    end
  endtask

  task automatic test_stall();
    bit stalled;
    int guard;
    apply_reset();
    for (int k = 0; k < 32; k++) begin
      drive(3 * tb_bitrev(k), tb_bitrev(k) + 7);
      tick();
    end
    bus.valid_i = 1'b0;
    stalled = 1'b0;
    guard = 0;
    while (rx.size() < 32 && guard < 80) begin
      if (!stalled && bus.valid_o === 1'b1 && bus.index_o === 5'd5) begin
        stalled = 1'b1;
        bus.ready_i = 1'b0;
        for (int s = 0; s < 4; s++) begin
          tick();
          vectors++;
          if (bus.valid_o !== 1'b1 || bus.index_o !== 5'd5 || bus.data_out_r !== 16'sd15 ||
              bus.data_out_i !== 16'sd12 || bus.sop_o !== 1'b0 || bus.eop_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got valid=%b idx=%0d r=%0d i=%0d sop=%b eop=%b want 1 5 15 12 0 0",
                     s, bus.valid_o, bus.index_o, bus.data_out_r, bus.data_out_i, bus.sop_o, bus.eop_o);
          end
        end
        bus.ready_i = 1'b1;
      end
      tick();
      guard++;
    end
    vectors++;
    if (stalled != 1'b1 || rx.size() != 32) begin
      miscompares++;
      $display("FAIL stall_run: got stalled=%b samples=%0d want 1 32", stalled, rx.size());
    end
    for (int n = 0; n < 32 && n < rx.size(); n++) begin
      vectors++;
      if (rx[n].r != 3 * n || rx[n].i != n + 7 || rx[n].idx != n || rx[n].eop != (n == 31)) begin
        miscompares++;
        $display("FAIL stall_sample%0d: got r=%0d i=%0d idx=%0d eop=%b want %0d %0d %0d %b",
                 n, rx[n].r, rx[n].i, rx[n].idx, rx[n].eop, 3 * n, n + 7, n, n == 31);
      end
    end
  endtask

  task automatic test_overflow();
    int v;
    apply_reset();
    bus.ready_i = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 32; k++) begin
        v = 300 + 100 * f + tb_bitrev(k);
        drive(v, -v);
        tick();
      end
    end
    vectors++;
    if (bus.overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_before: got %b want 0 with both banks just filled", bus.overflow_o);
    end
    drive(500, -500);
    tick();
    vectors++;
    if (bus.overflow_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: got %b want 1 after first sample of third frame", bus.overflow_o);
    end
    for (int k = 1; k < 32; k++) begin
      v = 500 + tb_bitrev(k);
      drive(v, -v);
      tick();
    end
    bus.valid_i = 1'b0;
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.index_o !== 5'd0 || bus.data_out_r !== 16'sd300) begin
      miscompares++;
      $display("FAIL ovf_holding: got valid=%b idx=%0d r=%0d want 1 0 300", bus.valid_o, bus.index_o, bus.data_out_r);
    end
    bus.ready_i = 1'b1;
    collect(64, 100);
    repeat (5) tick();
    vectors++;
    if (rx.size() != 64 || bus.valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_count: got samples=%0d valid=%b want 64 0", rx.size(), bus.valid_o);
    end
    for (int j = 0; j < 64 && j < rx.size(); j++) begin
      int n;
      n = j % 32;
      v = 300 + 100 * (j / 32) + n;
      vectors++;
      if (rx[j].r != v || rx[j].i != -v || rx[j].idx != n) begin
        miscompares++;
        $display("FAIL ovf_sample%0d: got r=%0d i=%0d idx=%0d want %0d %0d %0d", j, rx[j].r, rx[j].i, rx[j].idx, v, -v, n);
      end
    end
    vectors++;
    if (bus.overflow_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky: got %b want 1", bus.overflow_o);
    end
  endtask

  task automatic test_gapped();
    apply_reset();
    for (int k = 0; k < 32; k++) begin
      drive(tb_bitrev(k), tb_bitrev(k) + 1000);
      tick();
      bus.valid_i = 1'b0;
      bus.data_in_r = 16'sd999;
      tick();
    end
    collect(32, 60);
    vectors++;
    if (rx.size() != 32) begin
      miscompares++;
      $display("FAIL gap_count: got %0d samples want 32", rx.size());
    end
    for (int n = 0; n < 32 && n < rx.size(); n++) begin
      vectors++;
      if (rx[n].r != n || rx[n].i != n + 1000 || rx[n].idx != n) begin
        miscompares++;
        $display("FAIL gap_sample%0d: got r=%0d i=%0d idx=%0d want %0d %0d %0d", n, rx[n].r, rx[n].i, rx[n].idx, n, n + 1000, n);
      end
    end
  endtask

  task automatic test_reset_mid();
    int v;
    apply_reset();
    bus.ready_i = 1'b0;
    for (int k = 0; k < 32; k++) begin
      v = 600 + tb_bitrev(k);
      drive(v, -v);
      tick();
    end
    for (int k = 0; k < 17; k++) begin
      bus.ready_i = (k >= 7);
      v = 650 + tb_bitrev(k);
      drive(v, -v);
      tick();
    end
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.index_o !== 5'd10 || bus.data_out_r !== 16'sd610) begin
      miscompares++;
      $display("FAIL rm_setup: got valid=%b idx=%0d r=%0d want 1 10 610", bus.valid_o, bus.index_o, bus.data_out_r);
    end
    drive(650 + tb_bitrev(17), -(650 + tb_bitrev(17)));
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.sop_o !== 1'b0 || bus.eop_o !== 1'b0 || bus.overflow_o !== 1'b0 ||
        bus.index_o !== 5'd0 || bus.data_out_r !== 16'd0 || bus.data_out_i !== 16'd0) begin
      miscompares++;
      $display("FAIL rm_zero: got valid=%b sop=%b eop=%b ovf=%b idx=%0d r=%0d i=%0d want all 0",
               bus.valid_o, bus.sop_o, bus.eop_o, bus.overflow_o, bus.index_o, bus.data_out_r, bus.data_out_i);
    end
    bus.valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx.delete();
    bus.ready_i = 1'b1;
    repeat (4) tick();
    vectors++;
    if (bus.valid_o !== 1'b0 || rx.size() != 0) begin
      miscompares++;
      $display("FAIL rm_no_stale: got valid=%b samples=%0d want 0 0", bus.valid_o, rx.size());
    end
    for (int k = 0; k < 32; k++) begin
      v = 700 + tb_bitrev(k);
      drive(v, -v);
      tick();
    end
    bus.valid_i = 1'b0;
    collect(32, 60);
    vectors++;
    if (rx.size() != 32) begin
      miscompares++;
      $display("FAIL rm_count: got %0d samples want 32", rx.size());
    end
    for (int n = 0; n < 32 && n < rx.size(); n++) begin
      vectors++;
      if (rx[n].r != 700 + n || rx[n].i != -(700 + n) || rx[n].idx != n || rx[n].sop != (n == 0)) begin
        miscompares++;
        $display("FAIL rm_sample%0d: got r=%0d i=%0d idx=%0d sop=%b want %0d %0d %0d %b",
                 n, rx[n].r, rx[n].i, rx[n].idx, rx[n].sop, 700 + n, -(700 + n), n, n == 0);
      end
    end
  endtask

  initial begin
    bus.valid_i   = 1'b0;
    bus.data_in_r = '0;
    bus.data_in_i = '0;
    bus.ready_i   = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_gapped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1);
  end

endmodule
